// File: rtl/lsu.sv
// Load/store unit: drives one data-memory transaction at a time,
// aligns and extends load data, flags misaligned, illegal and timeout cases.
module lsu #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_rdata,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        stall,
    output logic        exc_valid,
    output logic [1:0]  exc_cause,
    output logic [31:0] exc_addr
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic [31:0]   addr_q;
    logic [4:0]    rd_q;
    logic [2:0]    f3_q;
    logic [1:0]    off_q;

    logic        accept, illegal, misal, go;
    logic        hs_resp, tmo, tmo_fire;
    logic [3:0]  wmask_d;
    logic [31:0] wdata_d, shifted, ext;

    assign req_ready     = rst_n & (state_q == IDLE);
    assign stall         = (state_q != IDLE);
    assign mem_req_valid = (state_q == REQ);
    assign accept        = req_valid & req_ready;
    assign go            = accept & ~illegal & ~misal;
    assign hs_resp       = (state_q == WAIT) & mem_resp_valid;
    assign tmo           = (cnt_q >= LAST);
    assign tmo_fire      = tmo & (((state_q == REQ) & ~mem_req_ready) |
                                  ((state_q == WAIT) & ~mem_resp_valid));

    // Decode legality and alignment of the incoming op
    always_comb begin
        if (req_we) begin
            illegal = (req_funct3 > 3'b010);
        end else begin
            illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
        end
        misal = 1'b0;
        if (!illegal) begin
            case (req_funct3[1:0])
                2'b01:   misal = req_addr[0];
                2'b10:   misal = |req_addr[1:0];
                default: misal = 1'b0;
            endcase
        end
    end

    // Place store bytes on their lanes and build the write mask
    always_comb begin
        wmask_d = 4'b0000;
        wdata_d = req_wdata;
        case (req_funct3[1:0])
            2'b00: begin
                wdata_d = {4{req_wdata[7:0]}};
                wmask_d = 4'b0001 << req_addr[1:0];
            end
            2'b01: begin
                wdata_d = {2{req_wdata[15:0]}};
                wmask_d = req_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: wmask_d = 4'b1111;
        endcase
        if (!req_we) begin
            wmask_d = 4'b0000;
        end
    end

    // Align the returned word and extend it to 32 bits
    always_comb begin
        shifted = mem_rdata >> {off_q, 3'b000};
        case (f3_q)
            3'b000:  ext = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  ext = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  ext = {24'b0, shifted[7:0]};
            3'b101:  ext = {16'b0, shifted[15:0]};
            default: ext = shifted;
        endcase
    end

    // Next-state logic; a handshake in the last cycle beats the timeout
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (go) state_d = REQ;
            REQ: begin
                if (mem_req_ready) begin
                    state_d = mem_we ? IDLE : WAIT;
                end else if (tmo) begin
                    state_d = IDLE;
                end
            end
            WAIT: if (mem_resp_valid || tmo) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request capture, timeout counter and registered wb/exc pulses
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wmask <= '0;
            wb_valid  <= 1'b0;
            wb_rd     <= '0;
            wb_data   <= '0;
            exc_valid <= 1'b0;
            exc_cause <= '0;
            exc_addr  <= '0;
            cnt_q     <= '0;
            addr_q    <= '0;
            rd_q      <= '0;
            f3_q      <= '0;
            off_q     <= '0;
        end else begin
            wb_valid  <= 1'b0;
            exc_valid <= 1'b0;
            if (state_q != IDLE) begin
                cnt_q <= cnt_q + CW'(1);
            end
            if (accept && (illegal || misal)) begin
                exc_valid <= 1'b1;
                exc_cause <= illegal ? 2'd3 : (req_we ? 2'd1 : 2'd0);
                exc_addr  <= req_addr;
            end
            if (go) begin
                mem_we    <= req_we;
                mem_addr  <= {req_addr[31:2], 2'b00};
                mem_wdata <= wdata_d;
                mem_wmask <= wmask_d;
                addr_q    <= req_addr;
                rd_q      <= req_rd;
                f3_q      <= req_funct3;
                off_q     <= req_addr[1:0];
                cnt_q     <= '0;
            end
            if (tmo_fire) begin
                exc_valid <= 1'b1;
                exc_cause <= 2'd2;
                exc_addr  <= addr_q;
            end
            if (hs_resp) begin
                wb_valid <= (rd_q != 5'd0);
                wb_rd    <= rd_q;
                wb_data  <= ext;
            end
        end
    end
endmodule

// File: tb/tb_lsu.sv
// Randomized scoreboard bench for lsu.
// Expected wb/exc events are queued at issue and popped by a monitor.
module tb_lsu;
    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic [4:0]  req_rd;
    logic        mem_req_valid, mem_req_ready, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_resp_valid;
    logic [31:0] mem_rdata;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        stall, exc_valid;
    logic [1:0]  exc_cause;
    logic [31:0] exc_addr;

    lsu #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .stall(stall), .exc_valid(exc_valid),
        .exc_cause(exc_cause), .exc_addr(exc_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_exc;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [1:0]  cause;
        logic [31:0] addr;
    } ev_t;

    ev_t sb[$];
    int  n_pass = 0;
    int  n_tot  = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Monitor: every output pulse must match the oldest expected event
    always @(negedge clk) begin
        if (rst_n && (wb_valid || exc_valid)) begin
            chk("wb_exc_both", 32'(wb_valid & exc_valid), 32'd0);
            if (sb.size() == 0) begin
                n_tot++;
                $display("FAIL unexpected_pulse: wb=%b exc=%b expected none",
                         wb_valid, exc_valid);
            end else begin
                ev_t e;
                e = sb.pop_front();
                chk("pulse_kind", 32'(exc_valid), 32'(e.is_exc));
                if (e.is_exc) begin
                    chk("exc_cause", 32'(exc_cause), 32'(e.cause));
                    chk("exc_addr", exc_addr, e.addr);
                end else begin
                    chk("wb_rd", 32'(wb_rd), 32'(e.rd));
                    chk("wb_data", wb_data, e.data);
                end
            end
        end
    end

    // Issue one op and play the memory side with the given delays.
    // dreq: idle REQ cycles before ready; dresp: cycles from handshake to data.
    task automatic do_op(input bit we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [4:0] rd, input logic [31:0] rdat,
                         input int dreq, input int dresp);
        bit          legal, tmo;
        int          sz, off, n_req, n_t, lim;
        ev_t         e;
        logic [3:0]  em;
        logic [31:0] ew, sh, ld;
        legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        sz    = 1 << f3[1:0];
        off   = int'(a[1:0]);
        @(posedge clk); #1;
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        req_rd     = rd;
        chk("req_ready", 32'(req_ready), 32'd1);
        if (!legal || (off % sz) != 0) begin
            e.is_exc = 1'b1;
            e.cause  = !legal ? 2'd3 : (we ? 2'd1 : 2'd0);
            e.addr   = a;
            e.rd     = '0;
            e.data   = '0;
            sb.push_back(e);
            @(posedge clk); #1;
            req_valid = 1'b0;
            chk("exc_latency", 32'(exc_valid), 32'd1);
            chk("exc_no_mem", 32'(mem_req_valid), 32'd0);
            chk("exc_stay_idle", 32'(req_ready), 32'd1);
            return;
        end
        for (int i = 0; i < 4; i++) begin
            em[i] = we && (i >= off) && (i < off + sz);
            ew[8*i +: 8] = wd[8*(i % sz) +: 8];
        end
        sh = rdat >> (8 * off);
        case (f3)
            3'd0:    ld = 32'($signed(sh[7:0]));
            3'd1:    ld = 32'($signed(sh[15:0]));
            3'd4:    ld = 32'(sh[7:0]);
            3'd5:    ld = 32'(sh[15:0]);
            default: ld = rdat;
        endcase
        n_req = dreq + 1;
        n_t   = we ? n_req : n_req + dresp;
        tmo   = (n_t > TMO);
        lim   = tmo ? TMO : n_t;
        if (tmo) begin
            e.is_exc = 1'b1; e.cause = 2'd2; e.addr = a;
            e.rd = '0; e.data = '0;
            sb.push_back(e);
        end else if (!we && rd != 5'd0) begin
            e.is_exc = 1'b0; e.rd = rd; e.data = ld;
            e.cause = '0; e.addr = '0;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int k = 1; k <= lim; k++) begin
            mem_req_ready  = (k == n_req);
            mem_resp_valid = (!we && k == n_req + dresp) ||
                             (k < n_req && $urandom_range(0, 3) == 0);
            mem_rdata      = (k == n_req + dresp) ? rdat : $urandom;
            chk("busy_stall", 32'(stall), 32'd1);
            chk("busy_not_ready", 32'(req_ready), 32'd0);
            if (k <= n_req) begin
                chk("mem_req_valid", 32'(mem_req_valid), 32'd1);
                chk("mem_addr", mem_addr, {a[31:2], 2'b00});
                chk("mem_we", 32'(mem_we), 32'(we));
                chk("mem_wmask", 32'(mem_wmask), 32'(em));
                if (we) chk("mem_wdata", mem_wdata, ew);
            end else begin
                chk("wait_no_req", 32'(mem_req_valid), 32'd0);
            end
            @(posedge clk); #1;
        end
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        chk("done_idle", 32'(stall), 32'd0);
        chk("wb_latency", 32'(wb_valid), 32'(!we && !tmo && rd != 5'd0));
        chk("tmo_latency", 32'(exc_valid), 32'(tmo));
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_mem_req_valid"}, 32'(mem_req_valid), 32'd0);
        chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        chk({tag, "_mem_wmask"}, 32'(mem_wmask), 32'd0);
        chk({tag, "_mem_addr"}, mem_addr, 32'd0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        chk({tag, "_wb_valid"}, 32'(wb_valid), 32'd0);
        chk({tag, "_wb_rd"}, 32'(wb_rd), 32'd0);
        chk({tag, "_wb_data"}, wb_data, 32'd0);
        chk({tag, "_exc_valid"}, 32'(exc_valid), 32'd0);
        chk({tag, "_exc_cause"}, 32'(exc_cause), 32'd0);
        chk({tag, "_exc_addr"}, exc_addr, 32'd0);
        chk({tag, "_stall"}, 32'(stall), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  lf[5];
        bit          we;
        logic [2:0]  f3;
        logic [31:0] a;
        int          dreq, dresp;
        lf = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        rst_n = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0;
        req_addr = '0; req_wdata = '0; req_rd = '0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk_zero_outputs("rst");
        rst_n = 1'b1;

        // Directed cases
        do_op(1'b0, 3'd0, 32'h103, 32'h0, 5'd7, 32'h80FF_1234, 0, 1);
        do_op(1'b1, 3'd1, 32'h202, 32'hDEAD_BEEF, 5'd0, 32'h0, 0, 1);
        do_op(1'b0, 3'd2, 32'h006, 32'h0, 5'd3, 32'h0, 0, 1);
        do_op(1'b0, 3'd3, 32'h100, 32'h0, 5'd3, 32'h0, 0, 1);
        do_op(1'b1, 3'd4, 32'h100, 32'h1, 5'd0, 32'h0, 0, 1);
        do_op(1'b1, 3'd2, 32'h101, 32'h1, 5'd0, 32'h0, 0, 1);
        do_op(1'b0, 3'd5, 32'h010, 32'h0, 5'd9, 32'hABCD_8001, 5, 1);
        do_op(1'b0, 3'd2, 32'h020, 32'h0, 5'd4, 32'h1234_5678, 20, 1);
        do_op(1'b1, 3'd2, 32'h024, 32'h5555_AAAA, 5'd0, 32'h0, 7, 1);
        do_op(1'b0, 3'd2, 32'h028, 32'h0, 5'd4, 32'h0BAD_F00D, 2, 5);
        do_op(1'b0, 3'd2, 32'h02C, 32'h0, 5'd4, 32'h0BAD_F00D, 2, 6);
        do_op(1'b0, 3'd1, 32'h032, 32'h0, 5'd0, 32'hFFFF_0000, 0, 2);

        // Reset while waiting for load data
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2;
        req_addr = 32'h40; req_rd = 5'd5;
        @(posedge clk); #1;
        req_valid = 1'b0; mem_req_ready = 1'b1;
        @(posedge clk); #1;
        mem_req_ready = 1'b0;
        chk("pre_rst_wait_stall", 32'(stall), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        chk_zero_outputs("midrst");
        rst_n = 1'b1;
        mem_resp_valid = 1'b1; mem_rdata = 32'hCAFE_BABE;
        @(posedge clk); #1;
        mem_resp_valid = 1'b0;
        chk("late_resp_no_wb", 32'(wb_valid), 32'd0);
        chk("late_resp_idle", 32'(stall), 32'd0);
        do_op(1'b0, 3'd2, 32'h44, 32'h0, 5'd6, 32'h1357_9BDF, 0, 1);

        // Randomized traffic
        repeat (200) begin
            we = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 4) != 0) begin
                f3 = we ? 3'($urandom_range(0, 2)) : lf[$urandom_range(0, 4)];
            end
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            if ($urandom_range(0, 9) == 0) dreq = $urandom_range(4, 9);
            else dreq = $urandom_range(0, 3);
            if (!we && dreq == TMO - 1) dreq = TMO;
            if ($urandom_range(0, 9) == 0) dresp = $urandom_range(3, 8);
            else dresp = $urandom_range(1, 3);
            do_op(we, f3, a, $urandom, 5'($urandom_range(0, 31)),
                  $urandom, dreq, dresp);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule

// File: doc/lsu.md
# lsu

Load/store unit for the 3-stage RISC-V core. Sits directly downstream of the execute-stage ALU: consumes the ALU result as the effective address together with rs2 store data and funct3, runs a valid/ready transaction with data memory, and returns aligned, sign- or zero-extended load data to writeback. Stalls the pipeline while a transaction is outstanding. Flags misaligned accesses, illegal funct3 and memory timeouts.

## Interface
- TIMEOUT_CYCLES, 255: maximum cycles a transaction may spend in REQ+WAIT before a bus-timeout exception.
- clk  in  1  core clock; all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- req_valid  in  1  execute stage presents a memory op
- req_ready  out  1  LSU accepts the op this cycle
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I load/store funct3
- req_addr  in  32  effective address (ALU Out)
- req_wdata  in  32  store data (rs2)
- req_rd  in  5  load destination register
- mem_req_valid  out  1  memory request valid
- mem_req_ready  in  1  memory accepts request
- mem_we  out  1  write enable
- mem_addr  out  32  word-aligned address
- mem_wdata  out  32  lane-replicated store data
- mem_wmask  out  4  byte write mask
- mem_resp_valid  in  1  load data valid
- mem_rdata  in  32  load data word
- wb_valid  out  1  one-cycle pulse: wb_data valid for wb_rd
- wb_rd  out  5  destination register
- wb_data  out  32  extended load result
- stall  out  1  pipeline hold
- exc_valid  out  1  one-cycle exception pulse
- exc_cause  out  2  0 load misaligned, 1 store misaligned, 2 bus timeout, 3 illegal funct3
- exc_addr  out  32  offending req_addr

## Operation
- FSM states: IDLE, REQ, WAIT. req_ready = rst_n & (state==IDLE). stall = (state!=IDLE).
- IDLE, req_valid=1: decode.
  - Illegal funct3: loads 011/110/111; stores anything above 010. Raises exc cause 3.
  - Misaligned: halfword with addr[0]=1, or word with addr[1:0]≠0. Raises cause 0 (load) or cause 1 (store).
  - On any exception: exc_valid pulses the next cycle with exc_addr=req_addr; no memory access; stay IDLE.
  - Otherwise: register mem_addr={addr[31:2],2'b00}, mem_we, mask, data, rd, funct3, offset; clear the timeout counter; go to REQ.
- Store lanes:
  - SB: wmask=4'b0001<<addr[1:0], wdata={4{rs2[7:0]}}.
  - SH: wmask=addr[1]?4'b1100:4'b0011, wdata={2{rs2[15:0]}}.
  - SW: 4'b1111, rs2.
- Loads drive wmask=0000.
- REQ: mem_req_valid=1. mem_* outputs are held stable until mem_req_ready.
  - On handshake, a store completes (posted) and the FSM goes to IDLE with no wb pulse.
  - On handshake, a load goes to WAIT.
- WAIT: on mem_resp_valid, extract data, then go to IDLE. mem_resp_valid is ignored outside WAIT.
- Load extraction: shift mem_rdata right by 8×offset.
  - LB/LH sign-extend bit 7/15; LBU/LHU zero-extend; LW passes through.
  - wb_valid pulses the next cycle with wb_rd and wb_data.
  - rd=0: response is consumed but wb_valid is suppressed.
- Timeout: a counter of width clog2(TIMEOUT_CYCLES+1) increments every cycle in REQ or WAIT.
  - If the count reaches TIMEOUT_CYCLES-1 without a completing handshake that cycle, exc cause 2 pulses next cycle with the captured address, and the FSM goes to IDLE.
  - A handshake in the final cycle wins over timeout.

## Timing
- Reset (rst_n low at edge): state=IDLE. wb_valid, exc_valid, mem_req_valid, mem_we, mem_wmask, wb_rd, wb_data, exc_cause, exc_addr, mem_addr, mem_wdata all 0. req_ready is 0 while rst_n is low.
- Reset mid-transaction: mem_req_valid drops at that edge; pending response is ignored; no wb or exc pulse.
- Load latency, accept at cycle T: mem_req_valid at T+1. With immediate ready, earliest response is T+2 and wb_valid is at T+3.
- Store latency: accept at T, handshake earliest T+1, IDLE at T+2.
- Exception latency: accept at T, exc_valid at T+1.
- wb_valid and exc_valid are registered and never both high.
- A new request may be accepted in the same cycle a wb or exc pulse is high (state is IDLE).
- Memory must not assert mem_resp_valid in the cycle of the request handshake.

## Test plan
- LB at addr 0x103; memory ready immediately; rdata=0x80FF_1234 next cycle -> mem_addr=0x100, wb_data=0xFFFF_FF80 at T+3, one-cycle pulse.
- SH at addr 0x202, rs2=0xDEAD_BEEF -> mem_wmask=1100, mem_wdata=0xBEEF_BEEF, mem_addr=0x200, no wb_valid, IDLE at T+2.
- LW at addr 0x006 -> exc_valid at T+1, cause 0, exc_addr=0x006, mem_req_valid never asserted; funct3=011 load -> cause 3.
- LHU at addr 0x10; hold mem_req_ready low 5 cycles -> mem_* stable throughout, stall=1; rdata=0xABCD_8001 -> wb_data=0x0000_8001.
- TIMEOUT_CYCLES=8, memory never ready -> exc cause 2 after exactly 8 REQ cycles. Ready asserted on the 8th cycle instead -> no exception.
- rst_n low during WAIT followed by a late mem_resp_valid -> no wb_valid; IDLE, outputs 0; next LW completes normally.
